ysyx_25040129_axi_arbiter: RTL and testbench

YSYX_25040129_AXI_ARBITER -- requirements
Module: ysyx_25040129_axi_arbiter

---
 rtl/ysyx_25040129_axi_arbiter_if.sv | 42 ++++
 rtl/ysyx_25040129_axi_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_ysyx_25040129_axi_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040129_axi_arbiter_if.sv
// rtl/ysyx_25040129_axi_arbiter_if.sv - AXI read/write channel bundle shared by the arbiter ports
// master drives AR/AW/W and the R/B readies; slave is the opposite side.
interface ysyx_25040129_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [7:0]            arlen;
  logic [1:0]            arburst;
  logic [2:0]            arsize;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [7:0]            awlen;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output arvalid, araddr, arlen, arburst, arsize, rready,
           awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );

  modport slave (
    input  arvalid, araddr, arlen, arburst, arsize, rready,
           awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_25040129_axi_arbiter.sv
// rtl/ysyx_25040129_axi_arbiter.sv - two-master (IFU m0, LSU m1) to one-slave AXI arbiter
// Reads are round-robin arbitrated; only m1 may write, on an independent write path.
module ysyx_25040129_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  ysyx_25040129_axi_arbiter_if.slave        m0,
  ysyx_25040129_axi_arbiter_if.slave        m1,
  ysyx_25040129_axi_arbiter_if.master       out,
  output logic                              err
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

  r_state_t              r_rstate, w_rnext;
  w_state_t              r_wstate, w_wnext;

  logic                  r_grant;       // 0 = m0, 1 = m1
  logic                  r_last_grant;
  logic [ADDR_W-1:0]     r_araddr;
  logic [7:0]            r_arlen;
  logic [7:0]            r_beat_cnt;
  logic                  r_err;

  logic                  r_aw_cap, r_w_cap, r_aw_done, r_w_done;
  logic [ADDR_W-1:0]     r_awaddr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;

  logic                  w_sel_m1, w_ar_hs, w_r_hs, w_rready_sel;
  logic                  w_aw_cap_hs, w_w_cap_hs, w_aw_out_hs, w_w_out_hs, w_b_hs;
  logic                  w_unused;

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    w_sel_m1 = 1'b0;
    if (m1.arvalid && (!m0.arvalid || !r_last_grant))
      w_sel_m1 = 1'b1;
  end

  assign w_rready_sel = r_grant ? m1.rready : m0.rready;

  always_comb begin
    w_rnext     = r_rstate;
    m0.arready  = 1'b0;
    m1.arready  = 1'b0;
    m0.rvalid   = 1'b0;
    m1.rvalid   = 1'b0;
    out.arvalid = 1'b0;
    out.rready  = 1'b0;
    w_ar_hs     = 1'b0;
    w_r_hs      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (reset && (m0.arvalid || m1.arvalid)) begin
          m0.arready = !w_sel_m1;
          m1.arready = w_sel_m1;
          w_ar_hs    = 1'b1;
          w_rnext    = R_ADDR;
        end
      end
      R_ADDR: begin
        out.arvalid = 1'b1;
        if (out.arready)
          w_rnext = R_DATA;
      end
      R_DATA: begin
        out.rready = w_rready_sel;
        m0.rvalid  = out.rvalid && !r_grant;
        m1.rvalid  = out.rvalid && r_grant;
        w_r_hs     = out.rvalid && w_rready_sel;
        if (w_r_hs && out.rlast)
          w_rnext = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) r_rstate <= R_IDLE;
    else        r_rstate <= w_rnext;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_beat_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_grant    <= w_sel_m1;
        r_araddr   <= w_sel_m1 ? m1.araddr : m0.araddr;
        r_arlen    <= w_sel_m1 ? m1.arlen  : m0.arlen;
        r_beat_cnt <= '0;
      end
      if (w_r_hs) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
        // The slave's rlast still ends the burst even when it disagrees with arlen.
        if (out.rlast != (r_beat_cnt == r_arlen))
          r_err <= 1'b1;
        if (out.rlast)
          r_last_grant <= r_grant;
      end
    end
  end

  assign out.araddr  = r_araddr;
  assign out.arlen   = r_arlen;
  assign out.arburst = 2'b01;
  assign out.arsize  = 3'b010;
  assign m0.rdata    = out.rdata;
  assign m0.rresp    = out.rresp;
  assign m0.rlast    = out.rlast;
  assign m1.rdata    = out.rdata;
  assign m1.rresp    = out.rresp;
  assign m1.rlast    = out.rlast;
  assign err         = r_err;

  always_comb begin
    w_wnext     = r_wstate;
    m1.awready  = 1'b0;
    m1.wready   = 1'b0;
    m1.bvalid   = 1'b0;
    out.awvalid = 1'b0;
    out.wvalid  = 1'b0;
    out.bready  = 1'b0;
    w_aw_cap_hs = 1'b0;
    w_w_cap_hs  = 1'b0;
    w_aw_out_hs = 1'b0;
    w_w_out_hs  = 1'b0;
    w_b_hs      = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        m1.awready  = reset && !r_aw_cap;
        m1.wready   = reset && !r_w_cap;
        w_aw_cap_hs = reset && !r_aw_cap && m1.awvalid;
        w_w_cap_hs  = reset && !r_w_cap && m1.wvalid;
        if ((r_aw_cap || w_aw_cap_hs) && (r_w_cap || w_w_cap_hs))
          w_wnext = W_REQ;
      end
      W_REQ: begin
        out.awvalid = !r_aw_done;
        out.wvalid  = !r_w_done;
        w_aw_out_hs = !r_aw_done && out.awready;
        w_w_out_hs  = !r_w_done && out.wready;
        if ((r_aw_done || w_aw_out_hs) && (r_w_done || w_w_out_hs))
          w_wnext = W_RESP;
      end
      W_RESP: begin
        m1.bvalid  = out.bvalid;
        out.bready = m1.bready;
        w_b_hs     = out.bvalid && m1.bready;
        if (w_b_hs)
          w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) r_wstate <= W_IDLE;
    else        r_wstate <= w_wnext;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_aw_cap  <= 1'b0;
      r_w_cap   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_b_hs) begin
      r_aw_cap  <= 1'b0;
      r_w_cap   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_cap_hs) begin
        r_aw_cap <= 1'b1;
        r_awaddr <= m1.awaddr;
      end
      if (w_w_cap_hs) begin
        r_w_cap <= 1'b1;
        r_wdata <= m1.wdata;
        r_wstrb <= m1.wstrb;
      end
      if (w_aw_out_hs) r_aw_done <= 1'b1;
      if (w_w_out_hs)  r_w_done  <= 1'b1;
    end
  end

  assign out.awaddr = r_awaddr;
  assign out.awlen  = 8'd0;
  assign out.wdata  = r_wdata;
  assign out.wstrb  = r_wstrb;
  assign out.wlast  = 1'b1;
  assign m1.bresp   = out.bresp;

  // m0 is read-only, so its write channels are never served.
  assign m0.awready = 1'b0;
  assign m0.wready  = 1'b0;
  assign m0.bvalid  = 1'b0;
  assign m0.bresp   = 2'b00;

  assign w_unused = ^{m0.arburst, m0.arsize, m0.awvalid, m0.awaddr, m0.awlen,
                      m0.wvalid, m0.wdata, m0.wstrb, m0.wlast, m0.bready,
                      m1.arburst, m1.arsize, m1.awlen, m1.wlast};

endmodule

// File: tb/tb_ysyx_25040129_axi_arbiter.sv
// tb/tb_ysyx_25040129_axi_arbiter.sv - directed self-checking bench for the AXI arbiter
module tb_ysyx_25040129_axi_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic err;

  always #5 clock = ~clock;

  ysyx_25040129_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  ysyx_25040129_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  ysyx_25040129_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) out_if ();

  ysyx_25040129_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .out   (out_if),
    .err   (err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Acts as the shared slave: accepts one AR after ar_delay stall cycles, then returns
  // beats 0..rlast_at with rlast on the final one, checking routing to the expected master.
  task automatic serve_read(input bit exp_m1, input logic [31:0] exp_addr,
                            input logic [7:0] exp_len, input int rlast_at,
                            input int ar_delay, input logic [31:0] dbase);
    int n;
    n = 0;
    #1;
    while (out_if.arvalid !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    check_eq("ar_valid", out_if.arvalid, 1);
    if (out_if.arvalid !== 1'b1) return;
    check_eq("ar_addr", out_if.araddr, exp_addr);
    check_eq("ar_len", out_if.arlen, exp_len);
    check_eq("ar_burst", out_if.arburst, 2'b01);
    check_eq("ar_size", out_if.arsize, 3'b010);
    check_eq("ar_busy_m0_arready", m0_if.arready, 0);
    check_eq("ar_busy_m1_arready", m1_if.arready, 0);
    for (int d = 0; d < ar_delay; d++) begin
      tick();
      #1;
      check_eq("ar_hold_valid", out_if.arvalid, 1);
      check_eq("ar_hold_addr", out_if.araddr, exp_addr);
      check_eq("ar_hold_len", out_if.arlen, exp_len);
    end
    out_if.arready = 1'b1;
    tick();
    out_if.arready = 1'b0;
    for (int b = 0; b <= rlast_at; b++) begin
      out_if.rvalid = 1'b1;
      out_if.rdata  = dbase + b;
      out_if.rlast  = (b == rlast_at);
      out_if.rresp  = 2'b00;
      #1;
      if (exp_m1) begin
        check_eq("r_m1_valid", m1_if.rvalid, 1);
        check_eq("r_m1_data", m1_if.rdata, dbase + b);
        check_eq("r_m1_last", m1_if.rlast, (b == rlast_at));
        check_eq("r_m0_quiet", m0_if.rvalid, 0);
      end else begin
        check_eq("r_m0_valid", m0_if.rvalid, 1);
        check_eq("r_m0_data", m0_if.rdata, dbase + b);
        check_eq("r_m0_last", m0_if.rlast, (b == rlast_at));
        check_eq("r_m1_quiet", m1_if.rvalid, 0);
      end
      check_eq("r_out_rready", out_if.rready, 1);
      check_eq("r_m0_arready", m0_if.arready, 0);
      check_eq("r_m1_arready", m1_if.arready, 0);
      check_eq("r_out_arvalid", out_if.arvalid, 0);
      tick();
    end
    out_if.rvalid = 1'b0;
    out_if.rlast  = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    {m0_if.arvalid, m0_if.araddr, m0_if.arlen, m0_if.arburst, m0_if.arsize, m0_if.rready} = '0;
    {m0_if.awvalid, m0_if.awaddr, m0_if.awlen, m0_if.wvalid, m0_if.wdata, m0_if.wstrb} = '0;
    {m0_if.wlast, m0_if.bready} = '0;
    {m1_if.arvalid, m1_if.araddr, m1_if.arlen, m1_if.arburst, m1_if.arsize, m1_if.rready} = '0;
    {m1_if.awvalid, m1_if.awaddr, m1_if.awlen, m1_if.wvalid, m1_if.wdata, m1_if.wstrb} = '0;
    {m1_if.wlast, m1_if.bready} = '0;
    {out_if.arready, out_if.rvalid, out_if.rdata, out_if.rresp, out_if.rlast} = '0;
    {out_if.awready, out_if.wready, out_if.bvalid, out_if.bresp} = '0;
    m0_if.rready = 1'b1;
    m1_if.rready = 1'b1;
    m1_if.bready = 1'b1;

    // Both masters request while reset is still held.
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h3000_0000; m0_if.arlen = 8'd3;
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h8000_0000; m1_if.arlen = 8'd0;
    repeat (2) tick();
    #1;
    check_eq("rst_m0_arready", m0_if.arready, 0);
    check_eq("rst_m1_arready", m1_if.arready, 0);
    check_eq("rst_m1_awready", m1_if.awready, 0);
    check_eq("rst_m1_wready", m1_if.wready, 0);
    check_eq("rst_out_arvalid", out_if.arvalid, 0);
    check_eq("rst_out_awvalid", out_if.awvalid, 0);
    check_eq("rst_out_wvalid", out_if.wvalid, 0);
    check_eq("rst_out_rready", out_if.rready, 0);
    check_eq("rst_m1_bvalid", m1_if.bvalid, 0);
    check_eq("rst_err", err, 0);

    reset = 1'b1;
    #1;
    check_eq("tie_first_m0_arready", m0_if.arready, 1);
    check_eq("tie_first_m1_arready", m1_if.arready, 0);
    tick();
    m0_if.arvalid = 1'b0;
    serve_read(1'b0, 32'h3000_0000, 8'd3, 3, 0, 32'hA000);
    #1;
    check_eq("second_m1_arready", m1_if.arready, 1);
    check_eq("second_m0_arready", m0_if.arready, 0);
    tick();
    m1_if.arvalid = 1'b0;
    serve_read(1'b1, 32'h8000_0000, 8'd0, 0, 0, 32'hB000);
    check_eq("good_bursts_err", err, 0);

    // Continuous requests from both masters alternate.
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0000_0100; m0_if.arlen = 8'd0;
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h0000_0200; m1_if.arlen = 8'd0;
    for (int i = 0; i < 4; i++) begin
      g = i[0];
      #1;
      check_eq("alt_m0_arready", m0_if.arready, !g);
      check_eq("alt_m1_arready", m1_if.arready, g);
      tick();
      serve_read(g, g ? 32'h0000_0200 : 32'h0000_0100, 8'd0, 0, 0, 32'hC000 + i * 16);
    end
    m0_if.arvalid = 1'b0;
    m1_if.arvalid = 1'b0;

    // Slave ends a len=3 burst early on beat 2.
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0000_0400; m0_if.arlen = 8'd3;
    #1;
    check_eq("early_m0_arready", m0_if.arready, 1);
    tick();
    m0_if.arvalid = 1'b0;
    serve_read(1'b0, 32'h0000_0400, 8'd3, 1, 0, 32'hD000);
    #1;
    check_eq("early_err_set", err, 1);

    // Back in idle, then a read whose AR is stalled five cycles.
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0000_0500; m0_if.arlen = 8'd0;
    #1;
    check_eq("post_err_idle_grant", m0_if.arready, 1);
    tick();
    m0_if.arvalid = 1'b0;
    serve_read(1'b0, 32'h0000_0500, 8'd0, 0, 5, 32'hE000);
    #1;
    check_eq("err_sticky", err, 1);

    // Single write: W arrives two cycles ahead of AW.
    m1_if.wvalid = 1'b1; m1_if.wdata = 32'hDEAD_BEEF; m1_if.wstrb = 4'hF;
    #1;
    check_eq("w_m1_wready", m1_if.wready, 1);
    check_eq("w_m1_awready", m1_if.awready, 1);
    tick();
    m1_if.wvalid = 1'b0;
    #1;
    check_eq("w_captured_wready", m1_if.wready, 0);
    check_eq("w_wait_out_wvalid", out_if.wvalid, 0);
    check_eq("w_wait_out_awvalid", out_if.awvalid, 0);
    tick();
    m1_if.awvalid = 1'b1; m1_if.awaddr = 32'h1000_0000;
    #1;
    check_eq("aw_m1_awready", m1_if.awready, 1);
    tick();
    m1_if.awvalid = 1'b0;
    #1;
    check_eq("wr_out_awvalid", out_if.awvalid, 1);
    check_eq("wr_out_awaddr", out_if.awaddr, 32'h1000_0000);
    check_eq("wr_out_awlen", out_if.awlen, 0);
    check_eq("wr_out_wvalid", out_if.wvalid, 1);
    check_eq("wr_out_wdata", out_if.wdata, 32'hDEAD_BEEF);
    check_eq("wr_out_wstrb", out_if.wstrb, 4'hF);
    check_eq("wr_out_wlast", out_if.wlast, 1);
    check_eq("wr_busy_awready", m1_if.awready, 0);
    check_eq("wr_busy_wready", m1_if.wready, 0);
    out_if.wready = 1'b1;
    tick();
    out_if.wready = 1'b0;
    #1;
    check_eq("wr_w_done", out_if.wvalid, 0);
    check_eq("wr_aw_pending", out_if.awvalid, 1);
    out_if.awready = 1'b1;
    tick();
    out_if.awready = 1'b0;
    #1;
    check_eq("wr_aw_done", out_if.awvalid, 0);
    check_eq("wr_resp_no_bvalid", m1_if.bvalid, 0);
    check_eq("wr_resp_no_awready", m1_if.awready, 0);
    check_eq("wr_resp_bready", out_if.bready, 1);
    out_if.bvalid = 1'b1; out_if.bresp = 2'b10;
    #1;
    check_eq("wr_m1_bvalid", m1_if.bvalid, 1);
    check_eq("wr_m1_bresp", m1_if.bresp, 2'b10);
    tick();
    out_if.bvalid = 1'b0;
    #1;
    check_eq("wr_done_bvalid", m1_if.bvalid, 0);
    check_eq("wr_idle_awready", m1_if.awready, 1);

    // Reset during the first data beat of a len=7 burst.
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h0000_0600; m1_if.arlen = 8'd7;
    #1;
    check_eq("mid_m1_arready", m1_if.arready, 1);
    tick();
    m1_if.arvalid = 1'b0;
    #1;
    check_eq("mid_out_arvalid", out_if.arvalid, 1);
    out_if.arready = 1'b1;
    tick();
    out_if.arready = 1'b0;
    out_if.rvalid = 1'b1; out_if.rlast = 1'b0; out_if.rdata = 32'hF000;
    #1;
    check_eq("mid_beat1_m1_rvalid", m1_if.rvalid, 1);
    reset = 1'b0;
    tick();
    #1;
    check_eq("rstmid_m1_rvalid", m1_if.rvalid, 0);
    check_eq("rstmid_m0_rvalid", m0_if.rvalid, 0);
    check_eq("rstmid_out_rready", out_if.rready, 0);
    check_eq("rstmid_out_arvalid", out_if.arvalid, 0);
    check_eq("rstmid_out_awvalid", out_if.awvalid, 0);
    check_eq("rstmid_out_wvalid", out_if.wvalid, 0);
    check_eq("rstmid_m1_bvalid", m1_if.bvalid, 0);
    check_eq("rstmid_err", err, 0);
    out_if.rvalid = 1'b0;
    reset = 1'b1;
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h0000_0700; m0_if.arlen = 8'd0;
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h0000_0800; m1_if.arlen = 8'd0;
    #1;
    check_eq("rel_tie_m0_arready", m0_if.arready, 1);
    check_eq("rel_tie_m1_arready", m1_if.arready, 0);
    tick();
    m0_if.arvalid = 1'b0;
    m1_if.arvalid = 1'b0;
    serve_read(1'b0, 32'h0000_0700, 8'd0, 0, 0, 32'h1234);
    #1;
    check_eq("final_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
